// File: rtl/checker_memory_arbiter_if.sv
// Bus bundle between the checker-memory arbiter and its MPU fetch, Wishbone and RAM neighbours.
interface checker_memory_arbiter_if #(
   parameter int ADDR_WIDTH = 12
);
   logic                  mpu_req;
   logic [ADDR_WIDTH-1:0] mpu_addr;
   logic [47:0]           mpu_do;
   logic                  mpu_ack;
   logic [31:0]           wb_adr_i;
   logic [31:0]           wb_dat_i;
   logic [31:0]           wb_dat_o;
   logic [3:0]            wb_sel_i;
   logic                  wb_stb_i;
   logic                  wb_cyc_i;
   logic                  wb_we_i;
   logic                  wb_ack_o;
   logic [ADDR_WIDTH-1:0] ram_adr_o;
   logic                  ram_en_o;
   logic [7:0]            ram_we_o;
   logic [63:0]           ram_dat_o;
   logic [63:0]           ram_dat_i;

   modport slave (
      input  mpu_req, mpu_addr, wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
             ram_dat_i,
      output mpu_do, mpu_ack, wb_dat_o, wb_ack_o, ram_adr_o, ram_en_o, ram_we_o, ram_dat_o
   );

   modport master (
      output mpu_req, mpu_addr, wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
             ram_dat_i,
      input  mpu_do, mpu_ack, wb_dat_o, wb_ack_o, ram_adr_o, ram_en_o, ram_we_o, ram_dat_o
   );
endinterface

// File: rtl/checker_memory_arbiter.sv
// Round-robin sharing of the checker-memory RAM port between MPU instruction fetch and
// a 32-bit Wishbone slave; one access in flight, every access returns through IDLE.
module checker_memory_arbiter #(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                     sys_clk,
   input  logic                     sys_rst,
   checker_memory_arbiter_if.slave  bus
);
   typedef enum logic [2:0] {IDLE, MPU_ACC, MPU_RESP, WB_ACC, WB_RESP} state_e;

   state_e                state_q, state_d;
   logic                  last_wb_q, last_wb_d;
   logic [ADDR_WIDTH-1:0] adr_q, adr_d;
   logic                  half_q, half_d;
   logic                  we_q, we_d;
   logic [3:0]            sel_q, sel_d;
   logic [31:0]           dat_q, dat_d;
   logic [47:0]           mpu_do_q, mpu_do_d;
   logic                  mpu_ack_q, mpu_ack_d;

   logic                  wb_req, mpu_req_v, grant_mpu;
   logic                  ram_en, wb_ack;
   logic [7:0]            ram_we;
   logic [31:0]           wb_dat;
   logic                  unused_adr;

   // The MPU keeps mpu_req up through its ack cycle; that cycle is not a new fetch.
   assign mpu_req_v  = bus.mpu_req & ~mpu_ack_q;
   assign wb_req     = bus.wb_cyc_i & bus.wb_stb_i;
   assign grant_mpu  = mpu_req_v & (~wb_req | last_wb_q);
   assign unused_adr = ^{bus.wb_adr_i[31:ADDR_WIDTH+3], bus.wb_adr_i[1:0]};

   always_comb begin
      state_d   = state_q;
      last_wb_d = last_wb_q;
      adr_d     = adr_q;
      half_d    = half_q;
      we_d      = we_q;
      sel_d     = sel_q;
      dat_d     = dat_q;
      mpu_do_d  = mpu_do_q;
      mpu_ack_d = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 8'h00;
      wb_ack    = 1'b0;
      wb_dat    = 32'h0;
      case (state_q)
         IDLE: begin
            if (grant_mpu) begin
               state_d   = MPU_ACC;
               last_wb_d = 1'b0;
               adr_d     = bus.mpu_addr;
               we_d      = 1'b0;
            end else if (wb_req) begin
               state_d   = WB_ACC;
               last_wb_d = 1'b1;
               adr_d     = bus.wb_adr_i[ADDR_WIDTH+2:3];
               half_d    = bus.wb_adr_i[2];
               we_d      = bus.wb_we_i;
               sel_d     = bus.wb_sel_i;
               dat_d     = bus.wb_dat_i;
            end
         end
         MPU_ACC: begin
            ram_en  = 1'b1;
            state_d = MPU_RESP;
         end
         MPU_RESP: begin
            mpu_do_d  = bus.ram_dat_i[47:0];
            mpu_ack_d = 1'b1;
            state_d   = IDLE;
         end
         WB_ACC: begin
            ram_en = 1'b1;
            if (we_q) ram_we = half_q ? {sel_q, 4'h0} : {4'h0, sel_q};
            state_d = WB_RESP;
         end
         WB_RESP: begin
            // A write already landed in WB_ACC; a dropped cycle only suppresses the ack.
            wb_ack = bus.wb_cyc_i;
            if (bus.wb_cyc_i) wb_dat = half_q ? bus.ram_dat_i[63:32] : bus.ram_dat_i[31:0];
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk) begin
      if (!sys_rst) begin
         state_q   <= IDLE;
         last_wb_q <= 1'b1;
         adr_q     <= '0;
         half_q    <= 1'b0;
         we_q      <= 1'b0;
         sel_q     <= 4'h0;
         dat_q     <= 32'h0;
         mpu_do_q  <= 48'h0;
         mpu_ack_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_wb_q <= last_wb_d;
         adr_q     <= adr_d;
         half_q    <= half_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         dat_q     <= dat_d;
         mpu_do_q  <= mpu_do_d;
         mpu_ack_q <= mpu_ack_d;
      end
   end

   assign bus.ram_adr_o = adr_q;
   assign bus.ram_dat_o = {dat_q, dat_q};
   assign bus.ram_en_o  = ram_en;
   assign bus.ram_we_o  = ram_we;
   assign bus.mpu_do    = mpu_do_q;
   assign bus.mpu_ack   = mpu_ack_q;
   assign bus.wb_ack_o  = wb_ack;
   assign bus.wb_dat_o  = wb_dat;
endmodule

// File: tb/tb_checker_memory_arbiter.sv
// Bench for checker_memory_arbiter: directed scenarios plus random traffic against a
// transaction-level model (shadow RAM, round-robin rule, fixed access latencies).
module tb_checker_memory_arbiter;
   localparam int AW = 12;

   logic sys_clk = 1'b0;
   logic sys_rst;
   always #5 sys_clk = ~sys_clk;

   checker_memory_arbiter_if #(.ADDR_WIDTH(AW)) bus ();
   checker_memory_arbiter #(.ADDR_WIDTH(AW)) dut (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus));

   // RAM neighbour: synchronous read-first, byte-lane writes
   logic [63:0] mem [0:(1<<AW)-1] = '{default: '0};
   always @(posedge sys_clk) begin
      if (bus.ram_en_o) begin
         bus.ram_dat_i <= mem[bus.ram_adr_o];
         for (int k = 0; k < 8; k++)
            if (bus.ram_we_o[k]) mem[bus.ram_adr_o][8*k +: 8] <= bus.ram_dat_o[8*k +: 8];
      end
   end

   typedef struct {
      bit          en;
      logic [AW-1:0] adr;
      logic [7:0]  we;
      logic [63:0] wdat;
      bit          mack;
      logic [47:0] mdat;
      bit          wresp;
      bit          wrd;
      logic [31:0] rdat;
   } exp_t;

   exp_t        sched [8];
   logic [63:0] shadow [0:(1<<AW)-1] = '{default: '0};
   int          n_cmp = 0, n_bad = 0, cyc = 0;
   int          next_free = 0, mpu_busy_until = -1;
   bit          last_wb = 1'b1;
   logic [47:0] mpu_do_exp = '0;
   int          wb_gnt_n = 0;
   int          obs_mpu_n = 0, obs_wb_n = 0, obs_mpu_cyc = 0, obs_wb_cyc = 0;
   logic [47:0] obs_mpu_do;
   logic [31:0] obs_wb_dat;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   // One clock: check this cycle's outputs mid-cycle, advance the model, return just after the edge.
   task automatic step();
      exp_t e;
      bit mw, ww, ack_exp, saw_m, saw_w, h;
      logic [AW-1:0] q;
      logic [7:0] we8;
      int s;
      @(negedge sys_clk);
      s = cyc % 8;
      e = sched[s];
      sched[s] = '{default: '0};
      chk("ram_en", 64'(bus.ram_en_o), 64'(e.en));
      chk("ram_we", 64'(bus.ram_we_o), 64'(e.we));
      if (e.en) chk("ram_adr", 64'(bus.ram_adr_o), 64'(e.adr));
      if (e.we != 8'h0) chk("ram_dat", bus.ram_dat_o, e.wdat);
      chk("mpu_ack", 64'(bus.mpu_ack), 64'(e.mack));
      if (e.mack) mpu_do_exp = e.mdat;
      chk("mpu_do", 64'(bus.mpu_do), 64'(mpu_do_exp));
      ack_exp = e.wresp && bus.wb_cyc_i;
      chk("wb_ack", 64'(bus.wb_ack_o), 64'(ack_exp));
      if (ack_exp && e.wrd) chk("wb_dat", 64'(bus.wb_dat_o), 64'(e.rdat));
      if (!ack_exp) chk("wb_dat_idle", 64'(bus.wb_dat_o), 64'h0);
      saw_m = (bus.mpu_ack === 1'b1);
      saw_w = (bus.wb_ack_o === 1'b1);
      if (saw_m) begin obs_mpu_n++; obs_mpu_cyc = cyc; obs_mpu_do = bus.mpu_do; end
      if (saw_w) begin obs_wb_n++;  obs_wb_cyc  = cyc; obs_wb_dat = bus.wb_dat_o; end

      if (!sys_rst) begin
         for (int i = 0; i < 8; i++) sched[i] = '{default: '0};
         next_free = cyc + 1; mpu_busy_until = cyc; last_wb = 1'b1; mpu_do_exp = '0;
      end else if (cyc >= next_free) begin
         mw = bus.mpu_req && (cyc > mpu_busy_until);
         ww = bus.wb_cyc_i && bus.wb_stb_i;
         if (mw && (!ww || last_wb)) begin
            sched[(cyc+1)%8].en   = 1'b1;
            sched[(cyc+1)%8].adr  = bus.mpu_addr;
            sched[(cyc+3)%8].mack = 1'b1;
            sched[(cyc+3)%8].mdat = shadow[bus.mpu_addr][47:0];
            mpu_busy_until = cyc + 3; next_free = cyc + 3; last_wb = 1'b0;
         end else if (ww) begin
            q   = bus.wb_adr_i[AW+2:3];
            h   = bus.wb_adr_i[2];
            we8 = bus.wb_we_i ? 8'({4'h0, bus.wb_sel_i} << (4*h)) : 8'h0;
            for (int k = 0; k < 8; k++)
               if (we8[k]) shadow[q][8*k +: 8] = bus.wb_dat_i[8*(k%4) +: 8];
            sched[(cyc+1)%8].en    = 1'b1;
            sched[(cyc+1)%8].adr   = q;
            sched[(cyc+1)%8].we    = we8;
            sched[(cyc+1)%8].wdat  = {bus.wb_dat_i, bus.wb_dat_i};
            sched[(cyc+2)%8].wresp = 1'b1;
            sched[(cyc+2)%8].wrd   = !bus.wb_we_i;
            sched[(cyc+2)%8].rdat  = h ? shadow[q][63:32] : shadow[q][31:0];
            next_free = cyc + 3; last_wb = 1'b1; wb_gnt_n++;
         end
      end
      cyc++;
      @(posedge sys_clk);
      #1;
      if (saw_m) bus.mpu_req = 1'b0;
      if (saw_w) begin bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; end
   endtask

   task automatic mpu_go(input logic [AW-1:0] a);
      bus.mpu_req = 1'b1; bus.mpu_addr = a;
   endtask

   task automatic wb_go(input bit we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
      bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = we;
      bus.wb_adr_i = a; bus.wb_dat_i = d; bus.wb_sel_i = sel;
   endtask

   task automatic wait_acks(input string tag, input int m, input int w);
      int t = 0;
      while ((obs_mpu_n < m || obs_wb_n < w) && t < 40) begin step(); t++; end
      chk({tag, "_mpu_acks"}, 64'(obs_mpu_n), 64'(m));
      chk({tag, "_wb_acks"}, 64'(obs_wb_n), 64'(w));
   endtask

   task automatic do_reset();
      sys_rst = 1'b0;
      repeat (3) step();
      sys_rst = 1'b1;
   endtask

   initial begin
      int c0, m0, w0, gseen;
      logic [3:0] q4;
      sys_rst = 1'b0;
      bus.mpu_req = 1'b0; bus.mpu_addr = '0;
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
      bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
      do_reset();

      // upper-half write, then low-half write and a fetch spanning both
      c0 = cyc; wb_go(1'b1, 32'h4, 32'hDEADBEEF, 4'hF); wait_acks("wr_hi", 0, 1);
      chk("wb_latency", 64'(obs_wb_cyc - c0), 64'd2);
      wb_go(1'b1, 32'h0, 32'h11223344, 4'hF); wait_acks("wr_lo", 0, 2);
      c0 = cyc; mpu_go('0); wait_acks("fetch0", 1, 2);
      chk("mpu_latency", 64'(obs_mpu_cyc - c0), 64'd3);
      chk("mpu_do_quad0", 64'(obs_mpu_do), 64'h0000_BEEF_1122_3344);

      // collisions: MPU wins after reset; WB wins when MPU was granted last
      do_reset();
      m0 = obs_mpu_n; w0 = obs_wb_n;
      mpu_go(12'd0); wb_go(1'b0, 32'h4, 32'h0, 4'hF); wait_acks("coll1", m0+1, w0+1);
      chk("coll1_mpu_first", 64'(obs_wb_cyc - obs_mpu_cyc), 64'd2);
      chk("coll1_rd", 64'(obs_wb_dat), 64'hDEADBEEF);
      mpu_go(12'd1); wait_acks("lone_mpu", m0+2, w0+1);
      mpu_go(12'd2); wb_go(1'b0, 32'h8, 32'h0, 4'hF); wait_acks("coll2", m0+3, w0+2);
      chk("coll2_wb_first", 64'(obs_mpu_cyc - obs_wb_cyc), 64'd4);

      // partial byte select over a full word
      wb_go(1'b1, 32'h8, 32'hFFFFFFFF, 4'hF); wait_acks("sel_pre", m0+3, w0+3);
      wb_go(1'b1, 32'h8, 32'h00000000, 4'h5); wait_acks("sel_wr", m0+3, w0+4);
      wb_go(1'b0, 32'h8, 32'h0, 4'hF);        wait_acks("sel_rd", m0+3, w0+5);
      chk("sel5_readback", 64'(obs_wb_dat), 64'hFF00FF00);

      // cycle dropped during the RAM cycle of a write
      w0 = obs_wb_n;
      wb_go(1'b1, 32'h10, 32'hCAFEF00D, 4'hF); step();
      bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
      repeat (3) step();
      chk("abort_no_ack", 64'(obs_wb_n), 64'(w0));
      wb_go(1'b0, 32'h10, 32'h0, 4'hF); wait_acks("abort_rd", obs_mpu_n, w0+1);
      chk("abort_readback", 64'(obs_wb_dat), 64'hCAFEF00D);

      // reset while the fetch is in its response cycle
      m0 = obs_mpu_n; w0 = obs_wb_n;
      mpu_go(12'd0); step(); step();
      sys_rst = 1'b0; step();
      sys_rst = 1'b1; bus.mpu_req = 1'b0;
      repeat (4) step();
      chk("rst_no_mpu_ack", 64'(obs_mpu_n), 64'(m0));
      chk("rst_mpu_do", 64'(bus.mpu_do), 64'h0);
      mpu_go(12'd3); wb_go(1'b0, 32'h0, 32'h0, 4'hF); wait_acks("coll3", m0+1, w0+1);
      chk("coll3_mpu_first", 64'(obs_wb_cyc - obs_mpu_cyc), 64'd2);

      // random traffic with occasional aborts and resets
      gseen = wb_gnt_n;
      for (int i = 0; i < 2000; i++) begin
         step();
         sys_rst = ($urandom_range(0, 399) != 0);
         if (!bus.mpu_req && $urandom_range(0, 2) == 0) mpu_go(AW'($urandom_range(0, 15)));
         if (wb_gnt_n != gseen) begin
            gseen = wb_gnt_n;
            if ($urandom_range(0, 7) == 0) begin bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; end
         end
         if (!bus.wb_stb_i && $urandom_range(0, 1) == 0) begin
            q4 = 4'($urandom_range(0, 15));
            wb_go(1'($urandom_range(0, 1)),
                  ($urandom & 32'hFFFF_8003) | (32'(q4) << 3) | (32'($urandom_range(0, 1)) << 2),
                  $urandom, 4'($urandom_range(0, 15)));
         end
      end
      sys_rst = 1'b1;
      repeat (6) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
